// File: rtl/status_flag_unit_if.sv
// Bundle of flag-unit signals between the ALU/sequencer side and the flag unit.
// The master drives flag writes, condition setup and stack commands; the slave returns state.
interface status_flag_unit_if #(
  parameter int FLAG_WIDTH  = 4,
  parameter int NUM_COND    = 2,
  parameter int STACK_DEPTH = 4
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic [FLAG_WIDTH-1:0]          status_in;
  logic                           status_write_en_in;
  logic [FLAG_WIDTH-1:0]          status_mask_in;
  logic [NUM_COND*FLAG_WIDTH-1:0] cond_sel_in;
  logic [NUM_COND*2-1:0]          cond_mode_in;
  logic [NUM_COND-1:0]            cond_eval_en_in;
  logic                           push_in;
  logic                           pop_in;
  logic                           err_clear_in;
  logic [FLAG_WIDTH-1:0]          status_out;
  logic [NUM_COND-1:0]            cond_out;
  logic [LVL_W-1:0]               stack_level_out;
  logic                           stack_full_out;
  logic                           stack_empty_out;
  logic                           stack_err_out;

  modport master (
    output status_in, status_write_en_in, status_mask_in, cond_sel_in, cond_mode_in,
           cond_eval_en_in, push_in, pop_in, err_clear_in,
    input  status_out, cond_out, stack_level_out, stack_full_out, stack_empty_out,
           stack_err_out
  );

  modport slave (
    input  status_in, status_write_en_in, status_mask_in, cond_sel_in, cond_mode_in,
           cond_eval_en_in, push_in, pop_in, err_clear_in,
    output status_out, cond_out, stack_level_out, stack_full_out, stack_empty_out,
           stack_err_out
  );
endinterface

// File: rtl/status_flag_unit.sv
// Status flag register with per-channel registered condition evaluation and a
// LIFO save/restore stack for interrupt/call entry and exit.
module status_flag_unit #(
  parameter int FLAG_WIDTH  = 4,
  parameter int NUM_COND    = 2,
  parameter int STACK_DEPTH = 4
) (
  input logic              clk_in,
  input logic              reset_n_in,
  status_flag_unit_if.slave bus
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  function automatic logic eval_cond(input logic [FLAG_WIDTH-1:0] f,
                                     input logic [FLAG_WIDTH-1:0] s,
                                     input logic [1:0]            m);
    logic any_hit;
    logic all_hit;
    any_hit = |(f & s);
    all_hit = &(f | ~s);
    case (m)
      2'b00:   eval_cond = any_hit;
      2'b01:   eval_cond = ~any_hit;
      2'b10:   eval_cond = all_hit;
      default: eval_cond = ~all_hit;
    endcase
  endfunction

  logic [FLAG_WIDTH-1:0] flags_p1;
  logic [NUM_COND-1:0]   cond_p1;
  logic [LVL_W-1:0]      lvl_p1;
  logic                  err_p1;
  logic [FLAG_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic                  push_ok_p0;
  logic                  pop_ok_p0;
  logic                  stack_fault_p0;
  logic [FLAG_WIDTH-1:0] pop_data_p0;
  logic [FLAG_WIDTH-1:0] flags_next_p0;

  // Stage p0: decode stack command; push+pop together is a no-op.
  always_comb begin
    push_ok_p0     = bus.push_in && !bus.pop_in && (lvl_p1 != LVL_W'(STACK_DEPTH));
    pop_ok_p0      = bus.pop_in && !bus.push_in && (lvl_p1 != '0);
    stack_fault_p0 = (bus.push_in && !bus.pop_in && (lvl_p1 == LVL_W'(STACK_DEPTH))) ||
                     (bus.pop_in && !bus.push_in && (lvl_p1 == '0));
  end

  always_comb begin
    pop_data_p0 = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (lvl_p1 == LVL_W'(i + 1)) pop_data_p0 = stack_mem[i];
    end
  end

  // A successful restore overrides the ALU write entirely, mask included.
  always_comb begin
    flags_next_p0 = flags_p1;
    if (pop_ok_p0)
      flags_next_p0 = pop_data_p0;
    else if (bus.status_write_en_in)
      flags_next_p0 = (flags_p1 & ~bus.status_mask_in) | (bus.status_in & bus.status_mask_in);
  end

  // Stage p1: registered state.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      flags_p1 <= '0;
      lvl_p1   <= '0;
      err_p1   <= 1'b0;
    end else begin
      flags_p1 <= flags_next_p0;
      if (push_ok_p0)
        lvl_p1 <= lvl_p1 + LVL_W'(1);
      else if (pop_ok_p0)
        lvl_p1 <= lvl_p1 - LVL_W'(1);
      if (stack_fault_p0)
        err_p1 <= 1'b1;
      else if (bus.err_clear_in)
        err_p1 <= 1'b0;
    end
  end

  // Conditions see the flags as they stood before this edge's write or restore.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      cond_p1 <= '0;
    end else begin
      for (int k = 0; k < NUM_COND; k++) begin
        if (bus.cond_eval_en_in[k])
          cond_p1[k] <= eval_cond(flags_p1, bus.cond_sel_in[k*FLAG_WIDTH +: FLAG_WIDTH],
                                  bus.cond_mode_in[2*k +: 2]);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push_ok_p0 && (lvl_p1 == LVL_W'(i))) stack_mem[i] <= flags_p1;
    end
  end

  assign bus.status_out      = flags_p1;
  assign bus.cond_out        = cond_p1;
  assign bus.stack_level_out = lvl_p1;
  assign bus.stack_full_out  = (lvl_p1 == LVL_W'(STACK_DEPTH));
  assign bus.stack_empty_out = (lvl_p1 == '0);
  assign bus.stack_err_out   = err_p1;
endmodule

// File: tb/tb_status_flag_unit.sv
// Bench for status_flag_unit: directed vector table, reset corners, and
// randomized traffic against a queue-based reference model.
module tb_status_flag_unit;
  localparam int FW = 4;
  localparam int NC = 2;
  localparam int SD = 4;

  logic clk_in = 1'b0;
  logic reset_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  status_flag_unit_if #(.FLAG_WIDTH(FW), .NUM_COND(NC), .STACK_DEPTH(SD)) bus ();

  status_flag_unit #(.FLAG_WIDTH(FW), .NUM_COND(NC), .STACK_DEPTH(SD)) dut (
    .clk_in    (clk_in),
    .reset_n_in(reset_n_in),
    .bus       (bus)
  );

  typedef struct {
    logic [3:0] st;
    logic       we;
    logic [3:0] mask;
    logic [7:0] sel;
    logic [3:0] mode;
    logic [1:0] en;
    logic       push;
    logic       pop;
    logic       clr;
    logic [3:0] e_st;
    logic [1:0] e_cond;
    int         e_lvl;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic vec_t V(logic [3:0] st, logic we, logic [3:0] mask, logic [7:0] sel,
                             logic [3:0] mode, logic [1:0] en, logic push, logic pop,
                             logic clr, logic [3:0] e_st, logic [1:0] e_cond, int e_lvl,
                             logic e_err);
    vec_t v;
    v.st = st; v.we = we; v.mask = mask; v.sel = sel; v.mode = mode; v.en = en;
    v.push = push; v.pop = pop; v.clr = clr;
    v.e_st = e_st; v.e_cond = e_cond; v.e_lvl = e_lvl; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic [3:0] st, logic we, logic [3:0] mask, logic [7:0] sel,
                       logic [3:0] mode, logic [1:0] en, logic push, logic pop, logic clr);
    bus.status_in = st; bus.status_write_en_in = we; bus.status_mask_in = mask;
    bus.cond_sel_in = sel; bus.cond_mode_in = mode; bus.cond_eval_en_in = en;
    bus.push_in = push; bus.pop_in = pop; bus.err_clear_in = clr;
  endtask

  task automatic chk_all(string tag, logic [3:0] st, logic [1:0] cnd, int lvl, logic err);
    chk({tag, ".status"}, int'(bus.status_out), int'(st));
    chk({tag, ".cond"}, int'(bus.cond_out), int'(cnd));
    chk({tag, ".level"}, int'(bus.stack_level_out), lvl);
    chk({tag, ".full"}, int'(bus.stack_full_out), int'(lvl == SD));
    chk({tag, ".empty"}, int'(bus.stack_empty_out), int'(lvl == 0));
    chk({tag, ".err"}, int'(bus.stack_err_out), int'(err));
  endtask

  // Reference model state
  logic [3:0] m_f;
  logic [1:0] m_cond;
  logic       m_err;
  logic [3:0] m_stack[$];

  function automatic logic ref_cond(logic [3:0] f, logic [3:0] s, logic [1:0] m);
    logic any_set, all_set;
    any_set = (f & s) != 4'd0;
    all_set = (f & s) == s;
    case (m)
      2'd0: return any_set;
      2'd1: return !any_set;
      2'd2: return all_set;
      default: return !all_set;
    endcase
  endfunction

  initial begin
    // Reset with every input active
    drive(4'hF, 1, 4'hF, 8'hFF, 4'hF, 2'b11, 1, 1, 1);
    #3;
    chk_all("reset_active", 4'h0, 2'b00, 0, 0);
    repeat (3) @(posedge clk_in);
    #1;
    chk_all("reset_held", 4'h0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);
    reset_n_in = 1'b1;

    vecs.push_back(V(4'b1010,1,4'b1111,8'h00,4'h0,2'b00,0,0,0, 4'b1010,2'b00,0,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'b1010_0011,4'b10_00,2'b11,0,0,0, 4'b1010,2'b11,0,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'b1010_0011,4'b10_01,2'b01,0,0,0, 4'b1010,2'b10,0,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'b1010_0011,4'b10_10,2'b01,0,0,0, 4'b1010,2'b10,0,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'b1010_0011,4'b10_11,2'b01,0,0,0, 4'b1010,2'b11,0,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'b0000_0000,4'b00_00,2'b00,0,0,0, 4'b1010,2'b11,0,0));
    vecs.push_back(V(4'b0101,1,4'b0011,8'h00,4'h0,2'b00,0,0,0, 4'b1001,2'b11,0,0));
    vecs.push_back(V(4'b0001,1,4'b1111,8'h00,4'h0,2'b00,0,0,0, 4'b0001,2'b11,0,0));
    vecs.push_back(V(4'b0010,1,4'b1111,8'h00,4'h0,2'b00,1,0,0, 4'b0010,2'b11,1,0));
    vecs.push_back(V(4'b0100,1,4'b1111,8'h00,4'h0,2'b00,1,0,0, 4'b0100,2'b11,2,0));
    vecs.push_back(V(4'b1000,1,4'b1111,8'h00,4'h0,2'b00,1,0,0, 4'b1000,2'b11,3,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'h00,4'h0,2'b00,1,0,0, 4'b1000,2'b11,4,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'h00,4'h0,2'b00,1,0,0, 4'b1000,2'b11,4,1));
    vecs.push_back(V(4'b0000,0,4'b0000,8'h00,4'h0,2'b00,0,1,0, 4'b1000,2'b11,3,1));
    vecs.push_back(V(4'b0000,0,4'b0000,8'h00,4'h0,2'b00,0,1,0, 4'b0100,2'b11,2,1));
    vecs.push_back(V(4'b0000,0,4'b0000,8'h00,4'h0,2'b00,0,1,0, 4'b0010,2'b11,1,1));
    vecs.push_back(V(4'b0000,0,4'b0000,8'h00,4'h0,2'b00,0,1,0, 4'b0001,2'b11,0,1));
    vecs.push_back(V(4'b0000,0,4'b0000,8'h00,4'h0,2'b00,0,0,1, 4'b0001,2'b11,0,0));
    vecs.push_back(V(4'b1111,1,4'b1111,8'h00,4'h0,2'b00,0,1,0, 4'b1111,2'b11,0,1));
    vecs.push_back(V(4'b0000,0,4'b0000,8'h00,4'h0,2'b00,0,0,1, 4'b1111,2'b11,0,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'h00,4'h0,2'b00,0,1,1, 4'b1111,2'b11,0,1));
    vecs.push_back(V(4'b0000,0,4'b0000,8'h00,4'h0,2'b00,0,0,1, 4'b1111,2'b11,0,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'h00,4'h0,2'b00,1,0,0, 4'b1111,2'b11,1,0));
    vecs.push_back(V(4'b0110,1,4'b1111,8'h00,4'h0,2'b00,0,0,0, 4'b0110,2'b11,1,0));
    vecs.push_back(V(4'b0000,1,4'b1111,8'h00,4'h0,2'b00,0,1,0, 4'b1111,2'b11,0,0));
    vecs.push_back(V(4'b0011,1,4'b1111,8'h00,4'h0,2'b00,1,0,0, 4'b0011,2'b11,1,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'h00,4'h0,2'b00,1,0,0, 4'b0011,2'b11,2,0));
    vecs.push_back(V(4'b0101,1,4'b1111,8'h00,4'h0,2'b00,1,1,0, 4'b0101,2'b11,2,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'h00,4'h0,2'b00,0,1,0, 4'b0011,2'b11,1,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'h00,4'h0,2'b00,0,1,0, 4'b1111,2'b11,0,0));
    vecs.push_back(V(4'b0000,1,4'b1111,8'b0000_1111,4'b00_01,2'b01,0,0,0, 4'b0000,2'b10,0,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'b0000_1111,4'b00_01,2'b01,0,0,0, 4'b0000,2'b11,0,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'b0000_0000,4'b11_00,2'b10,0,0,0, 4'b0000,2'b01,0,0));
    vecs.push_back(V(4'b0000,0,4'b0000,8'b0000_0000,4'b10_00,2'b10,0,0,0, 4'b0000,2'b11,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].we, vecs[i].mask, vecs[i].sel, vecs[i].mode, vecs[i].en,
            vecs[i].push, vecs[i].pop, vecs[i].clr);
      @(posedge clk_in);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_cond, vecs[i].e_lvl,
              vecs[i].e_err);
    end

    // Fresh reset, then random traffic against the model
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n_in = 1'b0;
    #2;
    @(negedge clk_in);
    reset_n_in = 1'b1;
    m_f = 4'h0; m_cond = 2'b00; m_err = 1'b0; m_stack.delete();
    @(posedge clk_in);
    #1;

    for (int c = 0; c < 300; c++) begin
      logic [3:0] st, mask;
      logic [7:0] sel;
      logic [3:0] mode;
      logic [1:0] en;
      logic we, push, pop, clr, fault;
      logic [3:0] f_pre;
      st = 4'($urandom); mask = 4'($urandom); sel = 8'($urandom); mode = 4'($urandom);
      en = 2'($urandom); we = ($urandom_range(0, 1) == 1);
      push = ($urandom_range(0, 99) < 35); pop = ($urandom_range(0, 99) < 30);
      clr = ($urandom_range(0, 99) < 15);
      drive(st, we, mask, sel, mode, en, push, pop, clr);

      f_pre = m_f;
      fault = 1'b0;
      for (int k = 0; k < NC; k++)
        if (en[k]) m_cond[k] = ref_cond(f_pre, sel[k*4 +: 4], mode[2*k +: 2]);
      if (push && !pop) begin
        if (m_stack.size() < SD) m_stack.push_back(f_pre);
        else fault = 1'b1;
      end
      if (pop && !push && m_stack.size() > 0) begin
        m_f = m_stack.pop_back();
      end else begin
        if (pop && !push) fault = 1'b1;
        if (we) m_f = (f_pre & ~mask) | (st & mask);
      end
      if (fault) m_err = 1'b1;
      else if (clr) m_err = 1'b0;

      @(posedge clk_in);
      #1;
      chk_all("rand", m_f, m_cond, m_stack.size(), m_err);
    end

    // Asynchronous reset mid-operation with a partly filled stack
    drive(4'h5, 1, 4'hF, 8'hFF, 4'h0, 2'b11, 1, 0, 0);
    repeat (2) @(posedge clk_in);
    #3;
    reset_n_in = 1'b0;
    #1;
    chk_all("midreset", 4'h0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk_all("post_midreset", 4'h0, 2'b00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Parametrised flag register with multi-channel condition evaluation and a hardware save/restore stack. It holds the CPU's ALU status flags, evaluates several registered branch/skip conditions per cycle in four test modes, and saves/restores the flags around interrupt or call entry/exit. It sits between the ALU flag outputs and the sequencer's conditional-execution logic.

## Interface
- FLAG_WIDTH, 4, number of status flags (>=1)
- NUM_COND, 2, independent condition channels (>=1)
- STACK_DEPTH, 4, save/restore stack entries (>=1)
- clk_in  input  1  clock; all state changes on rising edge
- reset_n_in  input  1  asynchronous, active-low reset
- status_in  input  FLAG_WIDTH  new flag values from ALU
- status_write_en_in  input  1  write flags
- status_mask_in  input  FLAG_WIDTH  per-bit write enable; only bits =1 take status_in
- cond_sel_in  input  NUM_COND*FLAG_WIDTH  flag select per channel; channel k in bits [k*FLAG_WIDTH +: FLAG_WIDTH]
- cond_mode_in  input  NUM_COND*2  mode per channel; channel k in bits [2k +: 2]
- cond_eval_en_in  input  NUM_COND  evaluate channel k this cycle
- push_in  input  1  save current flags onto stack
- pop_in  input  1  restore flags from stack
- err_clear_in  input  1  clear sticky stack error
- status_out  output  FLAG_WIDTH  current flag register
- cond_out  output  NUM_COND  registered condition results
- stack_level_out  output  $clog2(STACK_DEPTH+1)  occupied entries
- stack_full_out  output  1  level == STACK_DEPTH
- stack_empty_out  output  1  level == 0
- stack_err_out  output  1  sticky overflow/underflow flag

## Operation
- Flag register F; write: F[i] <= status_in[i] where status_mask_in[i]=1, else held.
- Channel k, with selected flags s = cond_sel_in[k], evaluated against F:
  - 00 ANY: |(F&s).
  - 01 NONE: ~|(F&s).
  - 10 ALL: &(F|~s); s=0 gives 1.
  - 11 NOT_ALL: ~ALL.
- cond_out[k] is updated only when cond_eval_en_in[k]=1 and holds otherwise; channels are independent.
- Evaluation always uses F as registered before the edge, never the value being written in the same cycle.
- Stack is LIFO with STACK_DEPTH entries and level counter L.
- push (pop=0): if L<STACK_DEPTH, store F (pre-write value) at L, L+1; else overflow: stack and L unchanged, stack_err_out<=1.
- pop (push=0): if L>0, F <= entry L-1 (all bits, mask ignored), L-1; else underflow: stack_err_out<=1, F unchanged by pop.
- push and pop in the same cycle: stack and L unchanged, no error.
- Write vs pop: a successful pop takes priority and the write is dropped. On underflow or push+pop, the write applies normally. A push never blocks a write.
- stack_err_out is sticky. err_clear_in clears it; an error event in the same cycle as the clear wins (flag stays 1).

## Timing
- Reset (asynchronous assert, synchronous to clk_in on release): F=0, cond_out=0, L=0, stack_empty_out=1, stack_full_out=0, stack_err_out=0. Stack contents are don't-care.
- Reset mid-operation discards all state immediately.
- Every output is registered; 1-cycle latency from input to status_out, cond_out, stack_level_out, and the full/empty/error outputs.
- Full and empty are decoded from the registered L and change in the cycle after a push or pop.
- There is no handshake. Push and pop take one cycle each and may be issued back to back every cycle.
- Evaluation that follows a write sees the new flags one cycle later, matching the previous-generation block.

## Test plan
- Reset with all inputs active -> status_out=0, cond_out=0, level=0, empty=1, err=0. Release reset, write 4'b1010 mask 4'b1111 -> status_out=4'b1010 next cycle.
- F=4'b1010, ch0 sel 4'b0011, each of the 4 modes -> ANY=1, NONE=0, ALL=0, NOT_ALL=1. ch1 sel 4'b1010 ALL -> 1. Drop eval_en -> cond_out holds.
- Masked write: F=4'b1010, status_in=4'b0101, mask=4'b0011 -> F=4'b1001.
- Push 4'b0001, 4'b0010, 4'b0100, 4'b1000 (DEPTH=4) -> full=1. Fifth push -> err=1, level stays 4. Four pops -> F=4'b1000, 4'b0100, 4'b0010, 4'b0001, empty=1.
- Pop when empty together with write 4'b1111 -> err=1, F=4'b1111. err_clear_in -> err=0. Pop+write with L=1 -> F=saved value, write dropped.
- Push+pop same cycle at L=2 -> L=2, err=0. Push+write -> saved entry is the pre-write F; a later pop restores it.
